mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port opcode  input  7  instr[6:0] taken from the instruction register.
REQ-004 SHALL have port funct3  input  3  instr[14:12].
REQ-005 SHALL have port funct7_5  input  1  instr[30].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  unified memory done; read data valid this cycle / write accepted this cycle.
REQ-008 SHALL have port mem_req  output  1  memory access request.
REQ-009 SHALL have port mem_we  output  1  1=write, 0=read; valid only while mem_req=1.
REQ-010 SHALL have port iord  output  1  memory address select: 0=PC, 1=ALU result.
REQ-011 SHALL have port ir_we  output  1  instruction register load.
REQ-012 SHALL have port pc_we  output  1  PC load.
REQ-013 SHALL have port pc_src  output  1  PC source: 0=PC+4, 1=PC+imm.
REQ-014 SHALL have port alusrc  output  1  ALU B operand: 0=rs2, 1=imm.
REQ-015 SHALL have port aluctrl  output  4  ALU operation code.
REQ-016 SHALL have port regwrite  output  1  register file write enable.
REQ-017 SHALL have port wb_sel  output  1  write-back source: 0=ALU result register, 1=memory data register.
REQ-018 SHALL have port state  output  3  current state, for debug.
REQ-019 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-020 SHALL have port retired  output  1  one-cycle pulse when an instruction completes.

Function
REQ-021 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, using the encodings from the package.
REQ-022 FETCH SHALL assert mem_req=1, mem_we=0, iord=0 and hold them until mem_ready=1.
REQ-023 In the FETCH cycle where mem_ready=1: ir_we=1, pc_we=1, pc_src=0, next state DECODE; no other cycle SHALL assert ir_we.
REQ-024 DECODE SHALL last one cycle and assert no enables.
REQ-025 DECODE next state SHALL be EXEC for the supported opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW) and 1100011 (BEQ).
REQ-026 DECODE with any other opcode SHALL pulse illegal=1 and return to FETCH; PC is already advanced and no other enables are asserted.
REQ-027 EXEC for R SHALL set alusrc=0, aluctrl from funct3/funct7_5, next WB.
REQ-028 EXEC for I-ALU SHALL set alusrc=1, aluctrl from funct3 with funct7_5 used only for shifts, next WB.
REQ-029 EXEC for LW/SW SHALL set alusrc=1, aluctrl=ADD, next MEM.
REQ-030 EXEC for BEQ SHALL set alusrc=0, aluctrl=SUB; if zero=1 then pc_we=1, pc_src=1; pulse retired; next FETCH.
REQ-031 MEM SHALL assert mem_req=1, iord=1, mem_we=1 for SW / 0 for LW, held until mem_ready=1.
REQ-032 In the MEM cycle with mem_ready=1: SW pulses retired and goes to FETCH; LW goes to WB.
REQ-033 WB SHALL assert regwrite=1, with wb_sel=1 for LW and 0 otherwise, pulse retired, next FETCH.
REQ-034 The opcode SHALL be sampled from the instruction register, which stays stable DECODE through WB; the block holds no copy of it.
REQ-035 Latency with zero-wait memory SHALL be BEQ 3, R/I/SW 4, LW 5 cycles; each wait cycle adds one.
REQ-036 Every output not listed for a state SHALL be 0; aluctrl defaults to ADD.
REQ-037 mem_req SHALL never deassert before mem_ready=1 within a FETCH or MEM visit.

Reset
REQ-038 rst_n=0 SHALL force state=FETCH immediately (asynchronously), from any state including mid-handshake.
REQ-039 While rst_n=0, all enables and pulses SHALL be 0; mem_req SHALL rise only after the first rising edge following rst_n deassertion.
REQ-040 After reset the first FETCH SHALL behave per REQ-022.

Structure
REQ-041 Package mc_pkg SHALL hold the state encodings (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4), the opcode constants and the ALU codes (ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, SRA=1000).
REQ-042 The ALU decode SHALL be a combinational sub-module mc_alu_dec (opcode, funct3, funct7_5 -> aluctrl).

Verification
REQ-043 R-type add (opcode 0110011, funct3 000, f7_5=0), mem_ready=1 -> states 0,1,2,4,0; aluctrl=0000 in EXEC; regwrite=1, wb_sel=0 in WB; retired in cycle 4.
REQ-044 LW with mem_ready low 2 cycles in MEM -> mem_req=1, iord=1, mem_we=0 held 3 cycles; then WB with wb_sel=1; 7 cycles total.
REQ-045 BEQ zero=1 -> EXEC asserts pc_we=1, pc_src=1, aluctrl=0001; BEQ zero=0 -> pc_we=0; 3 cycles either way.
REQ-046 Opcode 1111111 -> illegal pulse in DECODE, return to FETCH, regwrite/mem_req=0.
REQ-047 rst_n low during MEM wait of an SW -> state=0 and mem_req=0 asynchronously; mem_we never 1 after reset until next SW reaches MEM.
REQ-048 Fetch with mem_ready low 3 cycles -> ir_we/pc_we=0 until the 4th cycle, then both 1 for exactly one cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes and
// ALU operation codes, plus a small opcode classification helper.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    // True for the opcodes the datapath can execute.
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Unified-memory handshake between the controller (master) and memory (slave).
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational ALU operation decode from opcode/funct3/funct7 bit 5.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] aluctrl
);

    // Map instruction fields to an ALU operation; unknown encodings fall back to ADD.
    always_comb begin
        aluctrl = ALU_ADD;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000:  aluctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b001:  aluctrl = ALU_SLL;
                    3'b010:  aluctrl = ALU_SLT;
                    3'b011:  aluctrl = ALU_SLT;
                    3'b100:  aluctrl = ALU_XOR;
                    3'b101:  aluctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  aluctrl = ALU_OR;
                    3'b111:  aluctrl = ALU_AND;
                    default: aluctrl = ALU_ADD;
                endcase
            end
            OP_I: begin
                // Immediate forms have no SUB; bit 30 only selects arithmetic shift.
                case (funct3)
                    3'b000:  aluctrl = ALU_ADD;
                    3'b001:  aluctrl = ALU_SLL;
                    3'b010:  aluctrl = ALU_SLT;
                    3'b011:  aluctrl = ALU_SLT;
                    3'b100:  aluctrl = ALU_XOR;
                    3'b101:  aluctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  aluctrl = ALU_OR;
                    3'b111:  aluctrl = ALU_AND;
                    default: aluctrl = ALU_ADD;
                endcase
            end
            OP_LW, OP_SW: aluctrl = ALU_ADD;
            OP_BEQ:       aluctrl = ALU_SUB;
            default:      aluctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB Moore FSM driving the
// datapath enables and the unified-memory handshake.
// The opcode is read live from the instruction register, which holds steady
// from DECODE to WB, so no copy is kept here. Handshake-completion enables
// (ir_we/pc_we on mem_ready, branch pc_we on zero) must land in the same
// cycle as their qualifying input, so outputs are decoded from the state
// register and gated by active_r, which stays low until the first clock edge
// after reset release so that no request can appear during reset.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mc_ctrl_if.master         mem,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              zero,
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_src,
    output logic              alusrc,
    output logic [3:0]        aluctrl,
    output logic              regwrite,
    output logic              wb_sel,
    output logic [2:0]        state,
    output logic              illegal,
    output logic              retired
);

    state_e     state_r;
    logic       active_r;
    logic [3:0] dec_alu_s;
    logic       mem_req_s;
    logic       mem_we_s;
    logic       iord_s;

    mc_alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .aluctrl  (dec_alu_s)
    );

    // State sequencing; held in FETCH until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= FETCH;
            active_r <= 1'b0;
        end else if (!active_r) begin
            state_r  <= FETCH;
            active_r <= 1'b1;
        end else begin
            case (state_r)
                FETCH:   state_r <= mem.mem_ready ? DECODE : FETCH;
                DECODE:  state_r <= op_supported(opcode) ? EXEC : FETCH;
                EXEC: begin
                    case (opcode)
                        OP_LW, OP_SW: state_r <= MEM;
                        OP_BEQ:       state_r <= FETCH;
                        default:      state_r <= WB;
                    endcase
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        state_r <= (opcode == OP_LW) ? WB : FETCH;
                    end else begin
                        state_r <= MEM;
                    end
                end
                WB:      state_r <= FETCH;
                default: state_r <= FETCH;
            endcase
        end
    end

    // Per-state output decode; everything not driven by a state stays 0 / ADD.
    always_comb begin
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        iord_s    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alusrc    = 1'b0;
        aluctrl   = ALU_ADD;
        regwrite  = 1'b0;
        wb_sel    = 1'b0;
        illegal   = 1'b0;
        retired   = 1'b0;
        if (active_r) begin
            case (state_r)
                FETCH: begin
                    mem_req_s = 1'b1;
                    ir_we     = mem.mem_ready;
                    pc_we     = mem.mem_ready;
                end
                DECODE: begin
                    illegal = ~op_supported(opcode);
                end
                EXEC: begin
                    aluctrl = dec_alu_s;
                    alusrc  = (opcode != OP_R) && (opcode != OP_BEQ);
                    pc_we   = (opcode == OP_BEQ) && zero;
                    pc_src  = (opcode == OP_BEQ) && zero;
                    retired = (opcode == OP_BEQ);
                end
                MEM: begin
                    mem_req_s = 1'b1;
                    iord_s    = 1'b1;
                    mem_we_s  = (opcode == OP_SW);
                    retired   = (opcode == OP_SW) && mem.mem_ready;
                end
                WB: begin
                    regwrite = 1'b1;
                    wb_sel   = (opcode == OP_LW);
                    retired  = 1'b1;
                end
                default: begin
                    mem_req_s = 1'b0;
                end
            endcase
        end else begin
            mem_req_s = 1'b0;
        end
    end

    assign mem.mem_req = mem_req_s;
    assign mem.mem_we  = mem_we_s;
    assign mem.iord    = iord_s;
    assign state       = state_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each cycle compares the full output vector
// {state, aluctrl, flags} against hand-written expectations.
module tb_mc_ctrl;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    localparam logic [3:0] A_ADD = 4'b0000;
    localparam logic [3:0] A_SUB = 4'b0001;
    localparam logic [3:0] A_XOR = 4'b0100;
    localparam logic [3:0] A_SRA = 4'b1000;

    // flag bits: req we iord irwe pcwe pcsrc alusrc rw wbs ill ret
    localparam logic [10:0] F_REQ  = 11'b100_0000_0000;
    localparam logic [10:0] F_WE   = 11'b010_0000_0000;
    localparam logic [10:0] F_IORD = 11'b001_0000_0000;
    localparam logic [10:0] F_IRWE = 11'b000_1000_0000;
    localparam logic [10:0] F_PCWE = 11'b000_0100_0000;
    localparam logic [10:0] F_PCS  = 11'b000_0010_0000;
    localparam logic [10:0] F_ASRC = 11'b000_0001_0000;
    localparam logic [10:0] F_RW   = 11'b000_0000_1000;
    localparam logic [10:0] F_WBS  = 11'b000_0000_0100;
    localparam logic [10:0] F_ILL  = 11'b000_0000_0010;
    localparam logic [10:0] F_RET  = 11'b000_0000_0001;
    localparam logic [10:0] F_NONE = 11'b000_0000_0000;
    localparam logic [10:0] F_FET  = F_REQ;
    localparam logic [10:0] F_FOK  = F_REQ | F_IRWE | F_PCWE;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       ir_we, pc_we, pc_src, alusrc, regwrite, wb_sel, illegal, retired;
    logic [3:0] aluctrl;
    logic [2:0] state;
    int         n_checks;
    int         n_errors;

    mc_ctrl_if mif ();

    mc_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (mif),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .zero     (zero),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_src   (pc_src),
        .alusrc   (alusrc),
        .aluctrl  (aluctrl),
        .regwrite (regwrite),
        .wb_sel   (wb_sel),
        .state    (state),
        .illegal  (illegal),
        .retired  (retired)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [17:0] obs;
    assign obs = {state, aluctrl, mif.mem_req, mif.mem_we, mif.iord, ir_we, pc_we,
                  pc_src, alusrc, regwrite, wb_sel, illegal, retired};

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs just after a falling edge, compare, move to next falling edge.
    task automatic cyc(input string tag, input logic z, input logic rdy,
                       input logic [2:0] st, input logic [3:0] alu, input logic [10:0] fl);
        zero          = z;
        mif.mem_ready = rdy;
        #1;
        check_eq(tag, obs, {st, alu, fl});
        @(negedge clk);
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        zero          = 1'b0;
        mif.mem_ready = 1'b0;
        instr(R, 3'b000, 1'b0);
        #1;
        check_eq("reset_hold", obs, {3'd0, A_ADD, F_NONE});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // no request before the first rising edge after release
        cyc("post_rst_idle", 1'b0, 1'b1, 3'd0, A_ADD, F_NONE);

        // R add, zero-wait
        cyc("radd_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("radd_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("radd_exec",  1'b0, 1'b1, 3'd2, A_ADD, F_NONE);
        cyc("radd_wb",    1'b0, 1'b1, 3'd4, A_ADD, F_RW | F_RET);

        // R sub
        instr(R, 3'b000, 1'b1);
        cyc("rsub_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("rsub_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("rsub_exec",  1'b0, 1'b1, 3'd2, A_SUB, F_NONE);
        cyc("rsub_wb",    1'b0, 1'b1, 3'd4, A_ADD, F_RW | F_RET);

        // R xor
        instr(R, 3'b100, 1'b0);
        cyc("rxor_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("rxor_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("rxor_exec",  1'b0, 1'b1, 3'd2, A_XOR, F_NONE);
        cyc("rxor_wb",    1'b0, 1'b1, 3'd4, A_ADD, F_RW | F_RET);

        // I srai: bit 30 selects arithmetic shift
        instr(I, 3'b101, 1'b1);
        cyc("srai_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("srai_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("srai_exec",  1'b0, 1'b1, 3'd2, A_SRA, F_ASRC);
        cyc("srai_wb",    1'b0, 1'b1, 3'd4, A_ADD, F_RW | F_RET);

        // I addi with bit 30 set must still be ADD
        instr(I, 3'b000, 1'b1);
        cyc("addi_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("addi_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("addi_exec",  1'b0, 1'b1, 3'd2, A_ADD, F_ASRC);
        cyc("addi_wb",    1'b0, 1'b1, 3'd4, A_ADD, F_RW | F_RET);

        // LW with two memory wait cycles: 7 cycles
        instr(LW, 3'b010, 1'b0);
        cyc("lw_fetch",  1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("lw_dec",    1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("lw_exec",   1'b0, 1'b1, 3'd2, A_ADD, F_ASRC);
        cyc("lw_mem_w1", 1'b0, 1'b0, 3'd3, A_ADD, F_REQ | F_IORD);
        cyc("lw_mem_w2", 1'b0, 1'b0, 3'd3, A_ADD, F_REQ | F_IORD);
        cyc("lw_mem_ok", 1'b0, 1'b1, 3'd3, A_ADD, F_REQ | F_IORD);
        cyc("lw_wb",     1'b0, 1'b1, 3'd4, A_ADD, F_RW | F_WBS | F_RET);

        // SW zero-wait
        instr(SW, 3'b010, 1'b0);
        cyc("sw_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("sw_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("sw_exec",  1'b0, 1'b1, 3'd2, A_ADD, F_ASRC);
        cyc("sw_mem",   1'b0, 1'b1, 3'd3, A_ADD, F_REQ | F_WE | F_IORD | F_RET);

        // BEQ taken
        instr(BQ, 3'b000, 1'b0);
        cyc("beqt_fetch", 1'b1, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("beqt_dec",   1'b1, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("beqt_exec",  1'b1, 1'b1, 3'd2, A_SUB, F_PCWE | F_PCS | F_RET);

        // BEQ not taken
        cyc("beqn_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("beqn_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("beqn_exec",  1'b0, 1'b1, 3'd2, A_SUB, F_RET);

        // Illegal opcode
        instr(BAD, 3'b000, 1'b0);
        cyc("ill_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("ill_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_ILL);
        cyc("ill_back",  1'b0, 1'b0, 3'd0, A_ADD, F_FET);

        // Fetch with three wait cycles (continues from the FETCH above)
        instr(R, 3'b000, 1'b0);
        cyc("fw_w2",    1'b0, 1'b0, 3'd0, A_ADD, F_FET);
        cyc("fw_w3",    1'b0, 1'b0, 3'd0, A_ADD, F_FET);
        cyc("fw_ok",    1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("fw_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("fw_exec",  1'b0, 1'b1, 3'd2, A_ADD, F_NONE);
        cyc("fw_wb",    1'b0, 1'b1, 3'd4, A_ADD, F_RW | F_RET);

        // SW interrupted by reset during its memory wait
        instr(SW, 3'b010, 1'b0);
        cyc("swr_fetch", 1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("swr_dec",   1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("swr_exec",  1'b0, 1'b1, 3'd2, A_ADD, F_ASRC);
        cyc("swr_mem",   1'b0, 1'b0, 3'd3, A_ADD, F_REQ | F_WE | F_IORD);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("swr_async_rst", obs, {3'd0, A_ADD, F_NONE});
        @(negedge clk);
        check_eq("swr_rst_edge", obs, {3'd0, A_ADD, F_NONE});
        rst_n = 1'b1;
        cyc("swr_rel_idle", 1'b0, 1'b0, 3'd0, A_ADD, F_NONE);
        cyc("swr_refetch",  1'b0, 1'b1, 3'd0, A_ADD, F_FOK);
        cyc("swr_dec2",     1'b0, 1'b1, 3'd1, A_ADD, F_NONE);
        cyc("swr_exec2",    1'b0, 1'b1, 3'd2, A_ADD, F_ASRC);
        cyc("swr_mem2",     1'b0, 1'b1, 3'd3, A_ADD, F_REQ | F_WE | F_IORD | F_RET);
        cyc("swr_next",     1'b0, 1'b0, 3'd0, A_ADD, F_FET);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
